spi_slave_frontend: RTL and testbench
=====================================

# spi_slave_frontend

SPI slave front end directly upstream of the SPI RAM: it deserializes MOSI frames into 10-bit command/data words and presents them on `rx_data`/`rx_valid`. For read-data frames it waits for the RAM's `tx_valid`/`tx_data` and shifts the byte back out on MISO. The SPI clock is the system clock `clk`; the master drives MOSI and SS_n synchronous to it.

## Interface
- FRAME_WIDTH, 10, bits per MOSI frame (2 command bits + 8 payload bits)
- DATA_WIDTH, 8, bits returned on MISO per read-data frame
- clk  input  1  system/SPI clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- SS_n  input  1  slave select, active-low; frame boundary
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first; 0 when not shifting
- rx_data  output  FRAME_WIDTH  captured frame to RAM (`din`)
- rx_valid  output  1  one-cycle strobe, rx_data complete
- tx_data  input  DATA_WIDTH  read byte from RAM (`dout`)
- tx_valid  input  1  one-cycle strobe from RAM, tx_data valid

## Operation
- Reset: state IDLE; rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
- CHK_CMD: samples MOSI as frame bit 9. MOSI=0 -> WRITE. MOSI=1 and rd_addr_seen=0 -> READ_ADD. MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift MOSI into the frame register, MSB first, until 10 bits are taken (counter 0..9). On the 10th bit, load rx_data and assert rx_valid for exactly one cycle. Further MOSI bits while SS_n stays low are ignored.
- Command bits pass through unmodified. rx_data[9:8] is whatever the master sent; state selection uses only bit 9 and rd_addr_seen.
- rd_addr_seen is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- READ_DATA, after rx_valid: wait for tx_valid. On tx_valid=1, load tx_data into the output shifter. Drive MISO = bit 7 down to bit 0 on 8 consecutive cycles, then MISO=0. A tx_valid outside this wait window is ignored.
- SS_n=1 in any non-IDLE state -> IDLE next cycle. This aborts the partial frame (no rx_valid), stops MISO shifting (MISO=0), and clears the counters. rd_addr_seen changes only on completed frames.
- rst asserted mid-frame overrides everything and returns all state and outputs to reset values on the next edge.

## Timing
- Cycle numbering:
  - E0 is the edge where SS_n is first sampled 0.
  - Frame bits 9..0 are sampled at E1..E10.
  - rx_data/rx_valid are valid in the cycle after E10 and drop after E11.
- RAM response: the RAM registers at E11, so tx_valid/tx_data are visible after E11. The slave captures at E12. MISO carries bit 7 after E12 through bit 0 after E19, and returns to 0 after E20.
- SS_n must stay low through E20 for a full read-data frame. Deassertion earlier truncates MISO.
- Back-to-back frames: SS_n high for at least 1 cycle between frames.
- rx_valid never asserts on two consecutive cycles.

## Structure
- Package `spi_pkg`:
  - state enum typedef `spi_state_e`
  - FRAME_WIDTH and DATA_WIDTH constants
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11 (shared with the RAM and its bench)
- One sub-module `spi_miso_shifter`: load on tx_valid, 8-cycle MSB-first shift, abort input, busy flag.
- The FSM, receive shifter and counter live in the top level.

## Test plan
- Write address: SS_n low, MOSI frame 0_0_1010_0101 -> rx_valid one cycle after E10 with rx_data=10'h0A5; MISO stays 0; state waits for SS_n high.
- Write data: frame 01_0011_1100 -> rx_data=10'h13C, one rx_valid pulse.
- Read sequence: frame 10_0000_0111 (rx_data=10'h207, rd_addr_seen=1), then frame 11_xxxx_xxxx. Model the RAM returning tx_valid with tx_data=8'hC3 after E11 -> MISO = 1,1,0,0,0,0,1,1 after E12..E19, then 0; rd_addr_seen=0 afterwards.
- Read-data frame sent with rd_addr_seen=0 (MOSI bit 9=1) -> routed to READ_ADD; rd_addr_seen set; no MISO activity.
- SS_n raised after 5 bits -> no rx_valid, IDLE next cycle; the next full frame 00_1111_0000 captures correctly as 10'h0F0.
- rst asserted during MISO shifting (after E15) -> MISO=0, rx_valid=0, state IDLE, rd_addr_seen=0 on the next edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI front-end definitions: frame geometry, command encodings, FSM states.
// Command encodings are shared with the SPI RAM and its bench.
package spi_pkg;

    localparam int FRAME_WIDTH = 10;
    localparam int DATA_WIDTH  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_miso_shifter.sv
// MISO output shifter: loads a byte, drives it MSB first over WIDTH cycles, starting the cycle after load.
// No backpressure; abort or reset clears it immediately and forces MISO low.
module spi_miso_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    output logic             miso,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    remaining;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            shreg     <= din;
            remaining <= CW'(WIDTH);
        end else if (busy) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            remaining <= remaining - 1'b1;
        end
    end

    assign busy = (remaining != '0);
    assign miso = busy & shreg[WIDTH-1];

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: deserializes 10-bit MOSI frames to rx_data (rx_valid one cycle after the last bit)
// and returns the RAM read byte on MISO; no backpressure, SS_n high aborts the frame and returns to IDLE.
module spi_slave_frontend
    import spi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_valid
);

    localparam int CNT_W = $clog2(FRAME_WIDTH);

    spi_state_e             state_q;
    spi_state_e             state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_WIDTH-2:0] frame_sr;
    logic [FRAME_WIDTH-1:0] frame_next;
    logic                   frame_done;
    logic                   tx_taken;
    logic                   rd_addr_seen;
    logic                   shifting;
    logic                   tx_busy;
    logic                   tx_load;

    assign frame_next = {frame_sr, MOSI};
    assign shifting   = state_q inside {WRITE, READ_ADD, READ_DATA};
    // Only the first tx_valid after a completed read-data frame is accepted.
    assign tx_load    = (state_q == READ_DATA) && frame_done && !tx_taken &&
                        !tx_busy && tx_valid && !SS_n;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              state_nxt = IDLE;
                else if (!MOSI)        state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            default: begin
                if (SS_n) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt      <= '0;
            frame_sr     <= '0;
            frame_done   <= 1'b0;
            tx_taken     <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            rx_valid <= 1'b0;
            if (SS_n) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_taken   <= 1'b0;
            end else begin
                if (state_q == CHK_CMD) begin
                    frame_sr <= frame_next[FRAME_WIDTH-2:0];
                    bit_cnt  <= CNT_W'(1);
                end else if (shifting && !frame_done) begin
                    frame_sr <= frame_next[FRAME_WIDTH-2:0];
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(FRAME_WIDTH - 1)) begin
                        rx_data    <= frame_next;
                        rx_valid   <= 1'b1;
                        frame_done <= 1'b1;
                        if (state_q == READ_ADD)       rd_addr_seen <= 1'b1;
                        else if (state_q == READ_DATA) rd_addr_seen <= 1'b0;
                    end
                end
                if (tx_load) tx_taken <= 1'b1;
            end
        end
    end

    spi_miso_shifter #(.WIDTH(DATA_WIDTH)) u_miso (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .abort (SS_n),
        .din   (tx_data),
        .miso  (MISO),
        .busy  (tx_busy)
    );

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Bench for spi_slave_frontend: directed and random frames checked per edge against a frame-level model.
module tb_spi_slave_frontend;
    import spi_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [FRAME_WIDTH-1:0] rx_data;
    logic                   rx_valid;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   tx_valid;

    int tests = 0;
    int fails = 0;

    logic       obs_rxv  [32];
    logic       obs_miso [32];
    logic       exp_rxv  [32];
    logic       exp_miso [32];
    logic [9:0] obs_rxd;
    int         n_edges;
    bit         model_rd_seen;

    spi_slave_frontend dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame: E0 selects, E1..E10 carry bits 9..0, SS_n stays low through the
    // last edge of the frame, then one edge with SS_n high. Observations are indexed by edge.
    task automatic drive_frame(input logic [9:0] bits, input int nbits, input int extra,
                               input int tv_edge, input logic [7:0] txd, input int rst_edge);
        int last;
        int stop;
        last = (nbits == 10) ? 10 + extra : nbits;
        stop = (rst_edge >= 0) ? rst_edge : last;
        for (int k = 0; k <= stop + 1; k++) begin
            SS_n     = (k <= stop) ? 1'b0 : 1'b1;
            MOSI     = (k >= 1 && k <= 10) ? bits[10-k] : 1'($urandom);
            tx_valid = (k == tv_edge);
            tx_data  = (k == tv_edge) ? txd : 8'($urandom);
            rst      = (k == rst_edge);
            tick();
            obs_rxv[k]  = rx_valid;
            obs_miso[k] = MISO;
            if (k == 10) obs_rxd = rx_data;
        end
        n_edges  = stop + 2;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        rst      = 1'b0;
    endtask

    // Frame-level reference: what the frame means, not how the RTL sequences it.
    task automatic model_frame(input logic [9:0] bits, input int nbits, input int extra,
                               input int tv_edge, input logic [7:0] txd, input int rst_edge);
        int last;
        bit complete;
        bit is_rd_data;
        bit loads;
        last       = (nbits == 10) ? 10 + extra : nbits;
        complete   = (nbits == 10) && (rst_edge < 0 || rst_edge > 10);
        is_rd_data = bits[9] && model_rd_seen;
        loads      = complete && is_rd_data && tv_edge >= 11 && tv_edge <= last &&
                     (rst_edge < 0 || tv_edge < rst_edge);
        for (int k = 0; k < 32; k++) begin
            exp_rxv[k]  = complete && (k == 10);
            exp_miso[k] = 1'b0;
            if (loads && k >= tv_edge && k < tv_edge + 8 && k <= last &&
                (rst_edge < 0 || k < rst_edge))
                exp_miso[k] = txd[7-(k-tv_edge)];
        end
        if (rst_edge >= 0)           model_rd_seen = 1'b0;
        else if (complete && bits[9]) model_rd_seen = !is_rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick(); tick();
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset rx_valid got %b want 0", rx_valid); end
        tests++; if (rx_data !== 10'h000) begin fails++; $display("FAIL reset rx_data got %h want 000", rx_data); end
        tests++; if (MISO !== 1'b0) begin fails++; $display("FAIL reset MISO got %b want 0", MISO); end
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL reset state got %0d want IDLE", dut.state_q); end
        tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL reset rd_addr_seen got %b want 0", dut.rd_addr_seen); end
        rst = 1'b0;
        model_rd_seen = 1'b0;
        tick();
    endtask

    task automatic test_write_addr();
        logic [9:0] f;
        f = {CMD_WR_ADDR, 8'hA5};
        model_frame(f, 10, 3, -1, 8'h00, -1);
        drive_frame(f, 10, 3, -1, 8'h00, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL write_addr rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
            tests++; if (obs_miso[k] !== exp_miso[k]) begin fails++; $display("FAIL write_addr MISO E%0d got %b want %b", k, obs_miso[k], exp_miso[k]); end
        end
        tests++; if (obs_rxd !== 10'h0A5) begin fails++; $display("FAIL write_addr rx_data got %h want 0a5", obs_rxd); end
    endtask

    task automatic test_write_data();
        logic [9:0] f;
        f = {CMD_WR_DATA, 8'h3C};
        model_frame(f, 10, 0, -1, 8'h00, -1);
        drive_frame(f, 10, 0, -1, 8'h00, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL write_data rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
        end
        tests++; if (obs_rxd !== 10'h13C) begin fails++; $display("FAIL write_data rx_data got %h want 13c", obs_rxd); end
    endtask

    task automatic test_read_sequence();
        logic [9:0] fa;
        logic [9:0] fd;
        fa = {CMD_RD_ADDR, 8'h07};
        fd = {CMD_RD_DATA, 8'h5A};
        model_frame(fa, 10, 2, -1, 8'h00, -1);
        drive_frame(fa, 10, 2, -1, 8'h00, -1);
        tests++; if (obs_rxd !== 10'h207) begin fails++; $display("FAIL read_addr rx_data got %h want 207", obs_rxd); end
        tests++; if (dut.rd_addr_seen !== 1'b1) begin fails++; $display("FAIL read_addr rd_addr_seen got %b want 1", dut.rd_addr_seen); end
        model_frame(fd, 10, 10, 12, 8'hC3, -1);
        drive_frame(fd, 10, 10, 12, 8'hC3, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_miso[k] !== exp_miso[k]) begin fails++; $display("FAIL read_data MISO E%0d got %b want %b", k, obs_miso[k], exp_miso[k]); end
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL read_data rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
        end
        tests++; if (obs_rxd !== fd) begin fails++; $display("FAIL read_data rx_data got %h want %h", obs_rxd, fd); end
        tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL read_data rd_addr_seen got %b want 0", dut.rd_addr_seen); end
    endtask

    task automatic test_read_data_without_addr();
        logic [9:0] f;
        f = {CMD_RD_DATA, 8'hFF};
        model_frame(f, 10, 10, 12, 8'hFF, -1);
        drive_frame(f, 10, 10, 12, 8'hFF, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_miso[k] !== exp_miso[k]) begin fails++; $display("FAIL rd_no_addr MISO E%0d got %b want %b", k, obs_miso[k], exp_miso[k]); end
        end
        tests++; if (obs_rxd !== 10'h3FF) begin fails++; $display("FAIL rd_no_addr rx_data got %h want 3ff", obs_rxd); end
        tests++; if (dut.rd_addr_seen !== 1'b1) begin fails++; $display("FAIL rd_no_addr rd_addr_seen got %b want 1", dut.rd_addr_seen); end
    endtask

    task automatic test_abort();
        logic [9:0] f;
        f = {CMD_WR_ADDR, 8'hF0};
        model_frame(f, 5, 0, -1, 8'h00, -1);
        drive_frame(f, 5, 0, -1, 8'h00, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL abort rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
        end
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL abort state got %0d want IDLE", dut.state_q); end
        model_frame(f, 10, 1, -1, 8'h00, -1);
        drive_frame(f, 10, 1, -1, 8'h00, -1);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL after_abort rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
        end
        tests++; if (obs_rxd !== 10'h0F0) begin fails++; $display("FAIL after_abort rx_data got %h want 0f0", obs_rxd); end
    endtask

    task automatic test_reset_mid_shift();
        logic [9:0] f;
        f = {CMD_RD_DATA, 8'h11};
        tests++; if (dut.rd_addr_seen !== model_rd_seen) begin fails++; $display("FAIL rst_mid pre rd_addr_seen got %b want %b", dut.rd_addr_seen, model_rd_seen); end
        model_frame(f, 10, 10, 12, 8'hC3, 16);
        drive_frame(f, 10, 10, 12, 8'hC3, 16);
        for (int k = 0; k < n_edges; k++) begin
            tests++; if (obs_miso[k] !== exp_miso[k]) begin fails++; $display("FAIL rst_mid MISO E%0d got %b want %b", k, obs_miso[k], exp_miso[k]); end
            tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL rst_mid rx_valid E%0d got %b want %b", k, obs_rxv[k], exp_rxv[k]); end
        end
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL rst_mid state got %0d want IDLE", dut.state_q); end
        tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL rst_mid rd_addr_seen got %b want 0", dut.rd_addr_seen); end
        tests++; if (rx_data !== 10'h000) begin fails++; $display("FAIL rst_mid rx_data got %h want 000", rx_data); end
    endtask

    task automatic test_back_to_back_random();
        logic [9:0] f;
        logic [7:0] d;
        int nb;
        int ex;
        int tv;
        for (int i = 0; i < 40; i++) begin
            f  = 10'($urandom);
            d  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
            ex = $urandom_range(0, 14);
            tv = $urandom_range(8, 16);
            model_frame(f, nb, ex, tv, d, -1);
            drive_frame(f, nb, ex, tv, d, -1);
            for (int k = 0; k < n_edges; k++) begin
                tests++; if (obs_rxv[k] !== exp_rxv[k]) begin fails++; $display("FAIL rand%0d rx_valid E%0d got %b want %b", i, k, obs_rxv[k], exp_rxv[k]); end
                tests++; if (obs_miso[k] !== exp_miso[k]) begin fails++; $display("FAIL rand%0d MISO E%0d got %b want %b", i, k, obs_miso[k], exp_miso[k]); end
            end
            if (exp_rxv[10]) begin
                tests++; if (obs_rxd !== f) begin fails++; $display("FAIL rand%0d rx_data got %h want %h", i, obs_rxd, f); end
            end
            tests++; if (dut.rd_addr_seen !== model_rd_seen) begin fails++; $display("FAIL rand%0d rd_addr_seen got %b want %b", i, dut.rd_addr_seen, model_rd_seen); end
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_sequence();
        test_read_data_without_addr();
        test_abort();
        test_reset_mid_shift();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
